// File: rtl/ldst_ctrl_pkg.sv
// rtl/ldst_ctrl_pkg.sv - shared opcodes, ALU code, state encodings and strobe bundle for the ld/ldi/st sequencer
package ldst_ctrl_pkg;

   localparam logic [4:0] OPCODE_LD  = 5'b00000;
   localparam logic [4:0] OPCODE_LDI = 5'b00001;
   localparam logic [4:0] OPCODE_ST  = 5'b00010;
   localparam logic [4:0] ALU_OP_ADD = 5'b00011;

   localparam int MEM_WAIT_MIN = 1;
   localparam int MEM_WAIT_MAX = 15;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_F0   = 4'd1,
      S_F1   = 4'd2,
      S_F2   = 4'd3,
      S_DEC  = 4'd4,
      S_EA0  = 4'd5,
      S_EA1  = 4'd6,
      S_EA2  = 4'd7,
      S_LD0  = 4'd8,
      S_LD1  = 4'd9,
      S_ST0  = 4'd10,
      S_ST1  = 4'd11,
      S_FIN  = 4'd12
   } state_t;

   typedef struct packed {
      logic       pc_out;
      logic       inc_pc;
      logic       pc_in;
      logic       mar_in;
      logic       read;
      logic       write;
      logic       mdr_in;
      logic       mdr_out;
      logic       ir_in;
      logic       y_in;
      logic       z_in;
      logic       zlow_out;
      logic       gra;
      logic       grb;
      logic       r_in;
      logic       r_out;
      logic       ba_out;
      logic       c_out;
      logic [4:0] operation;
      logic       done;
   } ctrl_t;

   // Out-of-range wait counts are pulled into 1..15 so the 4-bit counter can always hold the reload.
   function automatic logic [3:0] mem_wait_reload(input int mem_wait);
      int w;
      w = mem_wait;
      if (w < MEM_WAIT_MIN) w = MEM_WAIT_MIN;
      if (w > MEM_WAIT_MAX) w = MEM_WAIT_MAX;
      return 4'(w - 1);
   endfunction

endpackage

// File: rtl/ldst_control_sequencer_mem_wait_counter.sv
// rtl/ldst_control_sequencer_mem_wait_counter.sv - 4-bit memory wait-state down counter with zero flag
module mem_wait_counter (
   input  logic       i_clk,
   input  logic       i_resetn,
   input  logic       i_load,
   input  logic [3:0] i_load_val,
   input  logic       i_dec,
   output logic       o_zero
);

   logic [3:0] r_count;

   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_count <= 4'd0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != 4'd0)) begin
         r_count <= r_count - 4'd1;
      end
   end

   assign o_zero = (r_count == 4'd0);

endmodule

// File: rtl/ldst_control_sequencer.sv
// rtl/ldst_control_sequencer.sv - Moore control sequencer for fetch and ld/ldi/st with memory wait states
module ldst_control_sequencer
   import ldst_ctrl_pkg::*;
#(
   parameter int               MEM_WAIT = 1,
   parameter int               OPC_W    = 5,
   parameter logic [OPC_W-1:0] OPC_LD   = OPCODE_LD,
   parameter logic [OPC_W-1:0] OPC_LDI  = OPCODE_LDI,
   parameter logic [OPC_W-1:0] OPC_ST   = OPCODE_ST,
   parameter logic [4:0]       ALU_ADD  = ALU_OP_ADD
) (
   input  logic             Clock,
   input  logic             Clear,
   input  logic             Run,
   input  logic [OPC_W-1:0] IR_opcode,
   output logic             PCout,
   output logic             IncPC,
   output logic             PCin,
   output logic             MARin,
   output logic             Read,
   output logic             Write,
   output logic             MDRin,
   output logic             MDRout,
   output logic             IRin,
   output logic             Yin,
   output logic             Zin,
   output logic             Zlowout,
   output logic             GRA,
   output logic             GRB,
   output logic             Rin,
   output logic             Rout,
   output logic             BAout,
   output logic             Cout,
   output logic [4:0]       operation,
   output logic             Done,
   output logic             Illegal,
   output logic [3:0]       State
);

   localparam logic [3:0] W_RELOAD = mem_wait_reload(MEM_WAIT);

   state_t r_state;
   state_t w_next;
   ctrl_t  r_ctrl;
   ctrl_t  w_ctrl;
   logic   r_illegal;
   logic   w_set_illegal;
   logic   w_wait_zero;
   logic   w_cur_mem;
   logic   w_next_mem;
   logic   w_is_ldi;
   logic   w_is_st;
   logic   w_legal;

   assign w_is_ldi   = (IR_opcode == OPC_LDI);
   assign w_is_st    = (IR_opcode == OPC_ST);
   assign w_legal    = (IR_opcode == OPC_LD) || w_is_ldi || w_is_st;
   assign w_cur_mem  = (r_state == S_F1) || (r_state == S_LD0) || (r_state == S_ST1);
   assign w_next_mem = (w_next == S_F1) || (w_next == S_LD0) || (w_next == S_ST1);

   mem_wait_counter u_wait (
      .i_clk      (Clock),
      .i_resetn   (Clear),
      .i_load     (w_next_mem && (w_next != r_state)),
      .i_load_val (W_RELOAD),
      .i_dec      (w_cur_mem),
      .o_zero     (w_wait_zero)
   );

   always_comb begin
      w_next        = r_state;
      w_set_illegal = 1'b0;
      case (r_state)
         S_IDLE: if (Run && !r_illegal) w_next = S_F0;
         S_F0:   w_next = S_F1;
         S_F1:   if (w_wait_zero) w_next = S_F2;
         S_F2:   w_next = S_DEC;
         S_DEC: begin
            if (w_legal) begin
               w_next = S_EA0;
            end else begin
               w_next        = S_IDLE;
               w_set_illegal = 1'b1;
            end
         end
         S_EA0:  w_next = S_EA1;
         S_EA1:  w_next = S_EA2;
         S_EA2:  w_next = w_is_ldi ? S_FIN : (w_is_st ? S_ST0 : S_LD0);
         S_LD0:  if (w_wait_zero) w_next = S_LD1;
         S_LD1:  w_next = S_FIN;
         S_ST0:  w_next = S_ST1;
         S_ST1:  if (w_wait_zero) w_next = S_FIN;
         S_FIN:  w_next = Run ? S_F0 : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Strobes are decoded from the next state and registered so they line up with State for the whole cycle.
   always_comb begin
      w_ctrl = '0;
      case (w_next)
         S_F0:  begin w_ctrl.pc_out = 1'b1; w_ctrl.mar_in = 1'b1; w_ctrl.inc_pc = 1'b1; w_ctrl.z_in = 1'b1; end
         S_F1:  begin w_ctrl.zlow_out = 1'b1; w_ctrl.pc_in = 1'b1; w_ctrl.read = 1'b1; w_ctrl.mdr_in = 1'b1; end
         S_F2:  begin w_ctrl.mdr_out = 1'b1; w_ctrl.ir_in = 1'b1; end
         S_EA0: begin w_ctrl.grb = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.ba_out = 1'b1; w_ctrl.y_in = 1'b1; end
         S_EA1: begin w_ctrl.c_out = 1'b1; w_ctrl.z_in = 1'b1; w_ctrl.operation = ALU_ADD; end
         S_EA2: begin
            w_ctrl.zlow_out = 1'b1;
            if (w_is_ldi) begin
               w_ctrl.gra  = 1'b1;
               w_ctrl.r_in = 1'b1;
            end else begin
               w_ctrl.mar_in = 1'b1;
            end
         end
         S_LD0: begin w_ctrl.read = 1'b1; w_ctrl.mdr_in = 1'b1; end
         S_LD1: begin w_ctrl.mdr_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1; end
         S_ST0: begin w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.mdr_in = 1'b1; end
         S_ST1: begin w_ctrl.mdr_out = 1'b1; w_ctrl.write = 1'b1; end
         S_FIN: w_ctrl.done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Clear) begin
         r_state   <= S_IDLE;
         r_ctrl    <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         r_ctrl  <= w_ctrl;
         if (w_set_illegal) r_illegal <= 1'b1;
      end
   end

   assign PCout     = r_ctrl.pc_out;
   assign IncPC     = r_ctrl.inc_pc;
   assign PCin      = r_ctrl.pc_in;
   assign MARin     = r_ctrl.mar_in;
   assign Read      = r_ctrl.read;
   assign Write     = r_ctrl.write;
   assign MDRin     = r_ctrl.mdr_in;
   assign MDRout    = r_ctrl.mdr_out;
   assign IRin      = r_ctrl.ir_in;
   assign Yin       = r_ctrl.y_in;
   assign Zin       = r_ctrl.z_in;
   assign Zlowout   = r_ctrl.zlow_out;
   assign GRA       = r_ctrl.gra;
   assign GRB       = r_ctrl.grb;
   assign Rin       = r_ctrl.r_in;
   assign Rout      = r_ctrl.r_out;
   assign BAout     = r_ctrl.ba_out;
   assign Cout      = r_ctrl.c_out;
   assign operation = r_ctrl.operation;
   assign Done      = r_ctrl.done;
   assign Illegal   = r_illegal;
   assign State     = r_state;

endmodule

// File: tb/tb_ldst_control_sequencer.sv
// tb/tb_ldst_control_sequencer.sv - directed and randomized check of the sequencer against a phase-list model
module tb_ldst_control_sequencer;
   import ldst_ctrl_pkg::*;

   localparam int B_PCOUT = 0, B_INCPC = 1, B_PCIN = 2, B_MARIN = 3, B_READ = 4, B_WRITE = 5;
   localparam int B_MDRIN = 6, B_MDROUT = 7, B_IRIN = 8, B_YIN = 9, B_ZIN = 10, B_ZLOWOUT = 11;
   localparam int B_GRA = 12, B_GRB = 13, B_RIN = 14, B_ROUT = 15, B_BAOUT = 16, B_COUT = 17;
   localparam logic [17:0] BUS_MASK = 18'h28881;

   typedef struct packed {
      logic [17:0] s;
      logic [4:0]  op;
      logic        done;
      logic [3:0]  st;
   } exp_t;

   logic        Clock = 1'b0;
   logic        Clear;
   logic        run0, run1;
   logic [4:0]  ir0, ir1;
   wire  [17:0] stb0, stb1;
   wire  [4:0]  op0, op1;
   wire         done0, done1, ill0, ill1;
   wire  [3:0]  st0, st1;

   int   n_assert = 0;
   int   n_fail   = 0;
   exp_t tr[$];

   always #5 Clock = ~Clock;

   ldst_control_sequencer #(.MEM_WAIT(1)) u_dut_w1 (
      .Clock(Clock), .Clear(Clear), .Run(run0), .IR_opcode(ir0),
      .PCout(stb0[0]), .IncPC(stb0[1]), .PCin(stb0[2]), .MARin(stb0[3]), .Read(stb0[4]), .Write(stb0[5]),
      .MDRin(stb0[6]), .MDRout(stb0[7]), .IRin(stb0[8]), .Yin(stb0[9]), .Zin(stb0[10]), .Zlowout(stb0[11]),
      .GRA(stb0[12]), .GRB(stb0[13]), .Rin(stb0[14]), .Rout(stb0[15]), .BAout(stb0[16]), .Cout(stb0[17]),
      .operation(op0), .Done(done0), .Illegal(ill0), .State(st0)
   );

   ldst_control_sequencer #(.MEM_WAIT(3)) u_dut_w3 (
      .Clock(Clock), .Clear(Clear), .Run(run1), .IR_opcode(ir1),
      .PCout(stb1[0]), .IncPC(stb1[1]), .PCin(stb1[2]), .MARin(stb1[3]), .Read(stb1[4]), .Write(stb1[5]),
      .MDRin(stb1[6]), .MDRout(stb1[7]), .IRin(stb1[8]), .Yin(stb1[9]), .Zin(stb1[10]), .Zlowout(stb1[11]),
      .GRA(stb1[12]), .GRB(stb1[13]), .Rin(stb1[14]), .Rout(stb1[15]), .BAout(stb1[16]), .Cout(stb1[17]),
      .operation(op1), .Done(done1), .Illegal(ill1), .State(st1)
   );

   function automatic int mw_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic logic [17:0] m(input int a, input int b, input int c, input int d);
      logic [17:0] r;
      r = '0;
      if (a >= 0) r[a] = 1'b1;
      if (b >= 0) r[b] = 1'b1;
      if (c >= 0) r[c] = 1'b1;
      if (d >= 0) r[d] = 1'b1;
      return r;
   endfunction

   function automatic void add(input logic [17:0] s, input logic [4:0] op, input logic dn,
                               input state_t st, input int n);
      exp_t e;
      e.s = s; e.op = op; e.done = dn; e.st = st;
      for (int i = 0; i < n; i++) tr.push_back(e);
   endfunction

   function automatic logic legal_opc(input logic [4:0] opc);
      return (opc == OPCODE_LD) || (opc == OPCODE_LDI) || (opc == OPCODE_ST);
   endfunction

   // Expected cycle-by-cycle trace of one instruction, starting at the first fetch cycle.
   function automatic void build(input logic [4:0] opc, input int mw);
      tr.delete();
      add(m(B_PCOUT, B_MARIN, B_INCPC, B_ZIN), 5'd0, 1'b0, S_F0, 1);
      add(m(B_ZLOWOUT, B_PCIN, B_READ, B_MDRIN), 5'd0, 1'b0, S_F1, mw);
      add(m(B_MDROUT, B_IRIN, -1, -1), 5'd0, 1'b0, S_F2, 1);
      add('0, 5'd0, 1'b0, S_DEC, 1);
      if (!legal_opc(opc)) return;
      add(m(B_GRB, B_ROUT, B_BAOUT, B_YIN), 5'd0, 1'b0, S_EA0, 1);
      add(m(B_COUT, B_ZIN, -1, -1), ALU_OP_ADD, 1'b0, S_EA1, 1);
      if (opc == OPCODE_LDI) begin
         add(m(B_ZLOWOUT, B_GRA, B_RIN, -1), 5'd0, 1'b0, S_EA2, 1);
      end else if (opc == OPCODE_LD) begin
         add(m(B_ZLOWOUT, B_MARIN, -1, -1), 5'd0, 1'b0, S_EA2, 1);
         add(m(B_READ, B_MDRIN, -1, -1), 5'd0, 1'b0, S_LD0, mw);
         add(m(B_MDROUT, B_GRA, B_RIN, -1), 5'd0, 1'b0, S_LD1, 1);
      end else begin
         add(m(B_ZLOWOUT, B_MARIN, -1, -1), 5'd0, 1'b0, S_EA2, 1);
         add(m(B_GRA, B_ROUT, B_MDRIN, -1), 5'd0, 1'b0, S_ST0, 1);
         add(m(B_MDROUT, B_WRITE, -1, -1), 5'd0, 1'b0, S_ST1, mw);
      end
      add('0, 5'd0, 1'b1, S_FIN, 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sample();
      @(negedge Clock);
      check("bus_single_driver_w1", 32'($countones(stb0 & BUS_MASK) <= 1), 32'd1);
      check("bus_single_driver_w3", 32'($countones(stb1 & BUS_MASK) <= 1), 32'd1);
      check("read_write_excl_w1", 32'(stb0[B_READ] & stb0[B_WRITE]), 32'd0);
      check("read_write_excl_w3", 32'(stb1[B_READ] & stb1[B_WRITE]), 32'd0);
   endtask

   task automatic set_in(input int k, input logic r, input logic [4:0] opc);
      if (k == 0) begin run0 = r; ir0 = opc; end
      else begin run1 = r; ir1 = opc; end
   endtask

   task automatic check_idle(input int k, input logic exp_ill);
      check("idle_state", 32'((k == 0) ? st0 : st1), 32'(S_IDLE));
      check("idle_strobes", 32'((k == 0) ? stb0 : stb1), 32'd0);
      check("idle_operation", 32'((k == 0) ? op0 : op1), 32'd0);
      check("idle_done", 32'((k == 0) ? done0 : done1), 32'd0);
      check("idle_illegal", 32'((k == 0) ? ill0 : ill1), 32'(exp_ill));
   endtask

   // Called at a falling edge with the DUT either idle or in FIN; the next rising edge enters F0.
   task automatic run_instr(input int k, input logic [4:0] opc, input bit keep_run, input bit abort_st1);
      int mw, done_at;
      bit legal;
      mw      = mw_of(k);
      legal   = legal_opc(opc);
      done_at = -1;
      build(opc, mw);
      set_in(k, 1'b1, opc);
      foreach (tr[i]) begin
         sample();
         check("state", 32'((k == 0) ? st0 : st1), 32'(tr[i].st));
         check("strobes", 32'((k == 0) ? stb0 : stb1), 32'(tr[i].s));
         check("operation", 32'((k == 0) ? op0 : op1), 32'(tr[i].op));
         check("done", 32'((k == 0) ? done0 : done1), 32'(tr[i].done));
         if (((k == 0) ? done0 : done1) && done_at < 0) done_at = i + 1;
         if (i == 0) set_in(k, keep_run || !legal, opc);
         if (abort_st1 && tr[i].st == S_ST1) begin
            Clear = 1'b0;
            sample();
            check_idle(k, 1'b0);
            Clear = 1'b1;
            return;
         end
      end
      if (!legal) begin
         for (int c = 0; c < 4; c++) begin
            sample();
            check_idle(k, 1'b1);
         end
         set_in(k, 1'b0, opc);
         Clear = 1'b0;
         sample();
         check_idle(k, 1'b0);
         Clear = 1'b1;
         return;
      end
      check("done_cycle", 32'(done_at), 32'((opc == OPCODE_LDI) ? 7 + mw : 8 + 2 * mw));
      if (!keep_run) begin
         sample();
         check_idle(k, 1'b0);
      end
   endtask

   initial begin
      int  k;
      bit  keep;
      logic [4:0] opc;
      Clear = 1'b0;
      set_in(0, 1'b0, 5'd0);
      set_in(1, 1'b0, 5'd0);
      repeat (2) sample();
      check_idle(0, 1'b0);
      check_idle(1, 1'b0);
      Clear = 1'b1;
      sample();

      run_instr(0, OPCODE_LD, 1'b0, 1'b0);
      run_instr(1, OPCODE_ST, 1'b0, 1'b0);
      run_instr(0, OPCODE_LDI, 1'b1, 1'b0);
      run_instr(0, OPCODE_LDI, 1'b0, 1'b0);
      run_instr(1, OPCODE_ST, 1'b0, 1'b1);
      run_instr(0, 5'b10110, 1'b0, 1'b0);
      run_instr(1, 5'b11111, 1'b0, 1'b0);

      k    = 0;
      keep = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (!keep) k = int'($urandom_range(0, 1));
         case ($urandom_range(0, 2))
            0:       opc = OPCODE_LD;
            1:       opc = OPCODE_LDI;
            default: opc = OPCODE_ST;
         endcase
         if ($urandom_range(0, 7) == 0) opc = 5'($urandom_range(3, 31));
         keep = (n != 39) && legal_opc(opc) && ($urandom_range(0, 1) == 1);
         run_instr(k, opc, keep, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
